// File: rtl/flappy_game_ctrl_pkg.sv
// Shared state encoding and datapath widths for the flappy game sequencer.
// Used by flappy_game_ctrl and its scroll burst generator.
package flappy_game_ctrl_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned BURST_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DYING = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    // Scroll pixels per frame: one extra step once the score reaches the speed-up threshold.
    function automatic logic [BURST_W-1:0] burst_len(input int unsigned base,
                                                      input logic [SCORE_W-1:0] score,
                                                      input int unsigned speedup);
        return BURST_W'(base) + ((score >= SCORE_W'(speedup)) ? BURST_W'(1) : BURST_W'(0));
    endfunction

endpackage

// File: rtl/flappy_game_ctrl_scroll_burst_gen.sv
// Frame-tick triggered generator of N consecutive count_en cycles.
// Ticks during an active burst are ignored; abort clears the burst at once.
module flappy_game_ctrl_scroll_burst_gen
    import flappy_game_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               tick,
    input  logic               abort,
    input  logic [BURST_W-1:0] len,
    output logic               count_en
);

    logic [BURST_W-1:0] cnt_q;
    logic [BURST_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (abort) begin
            cnt_d = '0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - BURST_W'(1);
        end else if (tick) begin
            cnt_d = len;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count_en = (cnt_q != '0);

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: round start/restart, frame-locked scroll bursts, lose line, best score.
// Optional best-score tracking is enabled by defining HISCORE_EN.
module flappy_game_ctrl
    import flappy_game_ctrl_pkg::*;
#(
    parameter int SPEED_BASE    = 2,
    parameter int SPEEDUP_SCORE = 8,
    parameter int INIT_CYCLES   = 2,
    parameter int DEATH_FRAMES  = 60
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               flap,
    input  logic               collide,
    input  logic [SCORE_W-1:0] score,
    output logic               pipe_rst,
    output logic               count_en,
    output logic               lose,
    output logic [STATE_W-1:0] state,
    output logic [SCORE_W-1:0] best_score
);

    state_e     state_q;
    state_e     state_d;
    logic       flap_q;
    logic       flap_edge;
    logic       play;
    logic       hit;
    logic [7:0] init_cnt_q;
    logic [7:0] init_cnt_d;
    logic [7:0] death_cnt_q;
    logic [7:0] death_cnt_d;

    assign flap_edge = flap & ~flap_q;
    assign play      = (state_q == ST_PLAY);
    assign hit       = play & collide;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        death_cnt_d = death_cnt_q;
        pipe_rst    = 1'b0;
        lose        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flap_edge) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            ST_INIT: begin
                pipe_rst = 1'b1;
                if (init_cnt_q == 8'(INIT_CYCLES - 1)) begin
                    state_d = ST_PLAY;
                end else begin
                    init_cnt_d = init_cnt_q + 8'd1;
                end
            end
            ST_PLAY: begin
                // Combinational so a score increment in the collision cycle is frozen.
                if (collide) begin
                    lose        = 1'b1;
                    state_d     = ST_DYING;
                    death_cnt_d = 8'(DEATH_FRAMES - 1);
                end
            end
            ST_DYING: begin
                lose = 1'b1;
                if (frame_tick) begin
                    if (death_cnt_q == '0) begin
                        state_d = ST_OVER;
                    end else begin
                        death_cnt_d = death_cnt_q - 8'd1;
                    end
                end
            end
            ST_OVER: begin
                lose = 1'b1;
                if (flap_edge) begin
                    state_d    = ST_INIT;
                    init_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            flap_q      <= 1'b0;
            init_cnt_q  <= '0;
            death_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flap_q      <= flap;
            init_cnt_q  <= init_cnt_d;
            death_cnt_q <= death_cnt_d;
        end
    end

    assign state = state_q;

    flappy_game_ctrl_scroll_burst_gen u_burst (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick & play),
        .abort    (~play | hit),
        .len      (burst_len(SPEED_BASE, score, SPEEDUP_SCORE)),
        .count_en (count_en)
    );

`ifdef HISCORE_EN
    logic [SCORE_W-1:0] best_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            best_q <= '0;
        end else if (hit && (score > best_q)) begin
            best_q <= score;
        end
    end

    assign best_score = best_q;
`else
    assign best_score = '0;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl: directed vectors, corner sequences and a
// randomized run against a behavioural model. Best-score expectations follow HISCORE_EN.
module tb_flappy_game_ctrl;
    import flappy_game_ctrl_pkg::*;

    localparam int SPEED_BASE    = 2;
    localparam int SPEEDUP_SCORE = 8;
    localparam int INIT_CYCLES   = 2;
    localparam int DEATH_FRAMES  = 60;

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       frame_tick = 1'b0;
    logic       flap       = 1'b0;
    logic       collide    = 1'b0;
    logic [3:0] score      = 4'd0;
    logic       pipe_rst;
    logic       count_en;
    logic       lose;
    logic [2:0] state;
    logic [3:0] best_score;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    flappy_game_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .flap       (flap),
        .collide    (collide),
        .score      (score),
        .pipe_rst   (pipe_rst),
        .count_en   (count_en),
        .lose       (lose),
        .state      (state),
        .best_score (best_score)
    );

    typedef struct {
        logic [3:0] sc;
        bit         second_tick;
        int         exp_len;
    } burst_vec_t;

    burst_vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        repeat (INIT_CYCLES) cyc();
    endtask

    task automatic end_round(input logic [3:0] sc);
        score   = sc;
        collide = 1'b1;
        cyc();
        collide = 1'b0;
        repeat (DEATH_FRAMES) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    function automatic int exp_best(input int b);
`ifdef HISCORE_EN
        return b;
`else
        return 0 * b;
`endif
    endfunction

    // Behavioural model: phase number plus "cycles/pixels/frames remaining" counts.
    int m_state, m_init_left, m_burst, m_frames, m_best;
    bit m_flap_prev;

    task automatic model_reset();
        m_state = 0; m_init_left = 0; m_burst = 0; m_frames = 0; m_best = 0;
        m_flap_prev = 1'b0;
    endtask

    task automatic model_step();
        bit fedge;
        fedge = flap && !m_flap_prev;
        case (m_state)
            0: if (fedge) begin m_state = 1; m_init_left = INIT_CYCLES; end
            1: begin
                m_init_left--;
                if (m_init_left == 0) m_state = 2;
            end
            2: begin
                if (collide) begin
                    m_state = 3; m_burst = 0; m_frames = DEATH_FRAMES;
                    if (int'(score) > m_best) m_best = int'(score);
                end else if (m_burst > 0) begin
                    m_burst--;
                end else if (frame_tick) begin
                    m_burst = SPEED_BASE + ((int'(score) >= SPEEDUP_SCORE) ? 1 : 0);
                end
            end
            3: if (frame_tick) begin
                m_frames--;
                if (m_frames == 0) m_state = 4;
            end
            4: if (fedge) begin m_state = 1; m_init_left = INIT_CYCLES; end
            default: m_state = 0;
        endcase
        m_flap_prev = flap;
    endtask

    task automatic model_check();
        check("rnd_state", int'(state), m_state);
        check("rnd_pipe_rst", int'(pipe_rst), (m_state == 1) ? 1 : 0);
        check("rnd_count_en", int'(count_en), (m_burst > 0) ? 1 : 0);
        check("rnd_lose", int'(lose), (m_state >= 3 || (m_state == 2 && collide)) ? 1 : 0);
        check("rnd_best", int'(best_score), exp_best(m_best));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len;
        int first;
        vecs[0] = '{4'd3,  1'b1, 2};
        vecs[1] = '{4'd8,  1'b0, 3};
        vecs[2] = '{4'd7,  1'b0, 2};
        vecs[3] = '{4'd15, 1'b1, 3};
        vecs[4] = '{4'd0,  1'b0, 2};
        vecs[5] = '{4'd9,  1'b1, 3};

        // Reset values, then an async reset mid-burst.
        repeat (2) cyc();
        check("rst_state", int'(state), 0);
        check("rst_pipe_rst", int'(pipe_rst), 0);
        check("rst_count_en", int'(count_en), 0);
        check("rst_lose", int'(lose), 0);
        reset = 1'b1;
        cyc();
        start_round();
        score      = 4'd3;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("pre_abort_count_en", int'(count_en), 1);
        reset = 1'b0;
        #1;
        check("abort_count_en", int'(count_en), 0);
        check("abort_state", int'(state), 0);
        check("abort_lose", int'(lose), 0);
        cyc();
        reset = 1'b1;
        cyc();
        check("post_rst_state", int'(state), 0);

        // First flap edge: pipe_rst for exactly INIT_CYCLES cycles, then PLAY.
        flap = 1'b1;
        #1;
        check("init_pre_pipe_rst", int'(pipe_rst), 0);
        cyc();
        flap = 1'b0;
        #1;
        check("init_c0_pipe_rst", int'(pipe_rst), 1);
        check("init_c0_state", int'(state), 1);
        collide = 1'b1;
        #1;
        check("init_collide_lose", int'(lose), 0);
        cyc();
        check("init_c1_pipe_rst", int'(pipe_rst), 1);
        check("init_c1_state", int'(state), 1);
        collide = 1'b0;
        cyc();
        check("init_done_pipe_rst", int'(pipe_rst), 0);
        check("init_done_state", int'(state), 2);

        // Burst length table.
        foreach (vecs[v]) begin
            len   = 0;
            first = -1;
            score      = vecs[v].sc;
            frame_tick = 1'b1;
            cyc();
            for (int k = 0; k < 8; k++) begin
                frame_tick = (vecs[v].second_tick && k == 0) ? 1'b1 : 1'b0;
                #1;
                if (count_en) begin
                    if (first < 0) first = k;
                    len++;
                end
                cyc();
            end
            frame_tick = 1'b0;
            check($sformatf("burst_len_%0d", v), len, vecs[v].exp_len);
            check($sformatf("burst_start_%0d", v), first, 0);
        end

        // Collide mid-burst, death countdown, flap held through DYING.
        score      = 4'd8;
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
        collide = 1'b1;
        #1;
        check("hit_lose_same_cycle", int'(lose), 1);
        cyc();
        collide = 1'b0;
        flap    = 1'b1;
        #1;
        check("hit_count_en", int'(count_en), 0);
        check("hit_state", int'(state), 3);
        check("hit_lose", int'(lose), 1);
        repeat (DEATH_FRAMES - 1) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
        check("dying_59_state", int'(state), 3);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        check("over_state", int'(state), 4);
        check("over_lose", int'(lose), 1);
        repeat (3) cyc();
        check("over_flap_held_state", int'(state), 4);
        flap = 1'b0;
        cyc();
        flap = 1'b1;
        cyc();
        flap = 1'b0;
        check("restart_state", int'(state), 1);
        repeat (INIT_CYCLES) cyc();

        // Best score across rounds.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        start_round();
        end_round(4'd5);
        check("hs_round1_state", int'(state), 4);
        check("hs_round1_best", int'(best_score), exp_best(5));
        start_round();
        end_round(4'd3);
        check("hs_round2_best", int'(best_score), exp_best(5));
        start_round();
        end_round(4'd9);
        check("hs_round3_best", int'(best_score), exp_best(9));

        // Illegal state code recovers to IDLE without pipe_rst/count_en.
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        cyc();
        force dut.state_q = state_e'(3'd5);
        #1;
        check("illegal_pipe_rst", int'(pipe_rst), 0);
        check("illegal_count_en", int'(count_en), 0);
        release dut.state_q;
        cyc();
        check("illegal_recover_state", int'(state), 0);
        check("illegal_recover_pipe_rst", int'(pipe_rst), 0);
        check("illegal_recover_count_en", int'(count_en), 0);

        // Randomized run against the model, with one async reset in the middle.
        reset = 1'b0;
        model_reset();
        cyc();
        reset = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) flap = ~flap;
            if ($urandom_range(0, 15) == 0) score = 4'($urandom_range(0, 15));
            collide = (m_state == 2) ? ($urandom_range(0, 39) == 0)
                                     : ($urandom_range(0, 3) == 0);
            if (i == 1300) reset = 1'b0;
            if (i == 1303) reset = 1'b1;
            if (!reset) model_reset();
            @(negedge clk);
            model_check();
            @(posedge clk);
            if (reset) model_step();
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
